// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared encodings for the RV32IM control unit: opcodes, ALU operations,
// operand/result selects and the decoded control bundle.
package ctrl_pkg;

    localparam int ALUOP_W  = 5;
    localparam int GPIO_MAX = 16;
    localparam int CNT_W    = 8;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_CSRRW  = 3'b001;

    localparam logic [1:0] SRC_RS2   = 2'b00;
    localparam logic [1:0] SRC_IMM12 = 2'b01;
    localparam logic [1:0] SRC_IMM20 = 2'b10;

    localparam logic [1:0] SEL_NONE  = 2'b00;
    localparam logic [1:0] SEL_IMM20 = 2'b01;
    localparam logic [1:0] SEL_ALU   = 2'b10;
    localparam logic [1:0] SEL_GPIO  = 2'b11;

    // Code 0 is reserved so a bubble drives an inert ALU operation.
    typedef enum logic [ALUOP_W-1:0] {
        ALU_NOP = '0,
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
        ALU_PASS
    } aluop_e;

    typedef struct packed {
        logic                regwrite;
        logic [1:0]          alusrc;
        logic [1:0]          regsel;
        aluop_e              aluop;
        logic [GPIO_MAX-1:0] gpio_we;
        logic [3:0]          gpio_rsel;
        logic                illegal;
        logic                is_div;
    } ctrl_bundle_t;

    typedef enum logic {
        ST_IDLE,
        ST_DIV_WAIT
    } state_e;

    function automatic ctrl_bundle_t illegal_bundle();
        ctrl_bundle_t b;
        b         = '0;
        b.illegal = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational instruction decoder producing the control bundle.
// M-extension encodings are decoded only when CTRL_MEXT_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int          NUM_GPIO      = 2,
    parameter logic [11:0] GPIO_OUT_BASE = 12'hF00,
    parameter logic [11:0] GPIO_IN_BASE  = 12'hF10
) (
    input  logic         instr_valid,
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    input  logic [11:0]  imm12,
    output ctrl_bundle_t ctrl
);

    logic [11:0] out_off;
    logic [11:0] in_off;
    logic        out_hit;
    logic        in_hit;

    // Addresses below a base wrap to large offsets, so one compare bounds both ends.
    assign out_off = imm12 - GPIO_OUT_BASE;
    assign in_off  = imm12 - GPIO_IN_BASE;
    assign out_hit = (out_off < 12'(NUM_GPIO));
    assign in_hit  = (in_off < 12'(NUM_GPIO));

    always_comb begin
        ctrl = '0;
        if (instr_valid) begin
            case (op)
                OP_R: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = SRC_RS2;
                    ctrl.regsel   = SEL_ALU;
                    case (funct7)
                        F7_BASE: begin
                            case (funct3)
                                3'b000:  ctrl.aluop = ALU_ADD;
                                3'b001:  ctrl.aluop = ALU_SLL;
                                3'b010:  ctrl.aluop = ALU_SLT;
                                3'b011:  ctrl.aluop = ALU_SLTU;
                                3'b100:  ctrl.aluop = ALU_XOR;
                                3'b101:  ctrl.aluop = ALU_SRL;
                                3'b110:  ctrl.aluop = ALU_OR;
                                default: ctrl.aluop = ALU_AND;
                            endcase
                        end
                        F7_ALT: begin
                            case (funct3)
                                3'b000:  ctrl.aluop = ALU_SUB;
                                3'b101:  ctrl.aluop = ALU_SRA;
                                default: ctrl = illegal_bundle();
                            endcase
                        end
`ifdef CTRL_MEXT_EN
                        F7_MULDIV: begin
                            ctrl.is_div = funct3[2];
                            case (funct3)
                                3'b000:  ctrl.aluop = ALU_MUL;
                                3'b001:  ctrl.aluop = ALU_MULH;
                                3'b010:  ctrl.aluop = ALU_MULHSU;
                                3'b011:  ctrl.aluop = ALU_MULHU;
                                3'b100:  ctrl.aluop = ALU_DIV;
                                3'b101:  ctrl.aluop = ALU_DIVU;
                                3'b110:  ctrl.aluop = ALU_REM;
                                default: ctrl.aluop = ALU_REMU;
                            endcase
                        end
`endif
                        default: ctrl = illegal_bundle();
                    endcase
                end
                OP_I: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = SRC_IMM12;
                    ctrl.regsel   = SEL_ALU;
                    case (funct3)
                        3'b000:  ctrl.aluop = ALU_ADD;
                        3'b001:  ctrl.aluop = ALU_SLL;
                        3'b010:  ctrl.aluop = ALU_SLT;
                        3'b011:  ctrl.aluop = ALU_SLTU;
                        3'b100:  ctrl.aluop = ALU_XOR;
                        3'b101:  ctrl.aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  ctrl.aluop = ALU_OR;
                        default: ctrl.aluop = ALU_AND;
                    endcase
                end
                OP_LUI: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = SRC_IMM20;
                    ctrl.regsel   = SEL_IMM20;
                    ctrl.aluop    = ALU_PASS;
                end
                OP_SYS: begin
                    if (funct3 == F3_CSRRW && out_hit) begin
                        ctrl.gpio_we = {{(GPIO_MAX-1){1'b0}}, 1'b1} << out_off[3:0];
                    end else if (funct3 == F3_CSRRW && in_hit) begin
                        ctrl.regwrite  = 1'b1;
                        ctrl.regsel    = SEL_GPIO;
                        ctrl.gpio_rsel = in_off[3:0];
                    end else begin
                        ctrl = illegal_bundle();
                    end
                end
                default: ctrl = illegal_bundle();
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// EX-stage control registers and the fixed-latency DIV/REM sequencer.
// The sequencer exists only when CTRL_MEXT_EN is defined.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int          NUM_GPIO      = 2,
    parameter logic [11:0] GPIO_OUT_BASE = 12'hF00,
    parameter logic [11:0] GPIO_IN_BASE  = 12'hF10,
    parameter int          DIV_CYCLES    = 34,
    parameter int          ALUOP_W       = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic [11:0]         imm12,
    output logic                regwrite_EX,
    output logic [1:0]          alusrc_EX,
    output logic [1:0]          regsel_EX,
    output logic [ALUOP_W-1:0]  aluop_EX,
    output logic [NUM_GPIO-1:0] gpio_we_EX,
    output logic [3:0]          gpio_rsel_EX,
    output logic                div_start,
    output logic                stall_FE,
    output logic                illegal_EX
);

    ctrl_bundle_t dec;

    logic                regwrite_d;
    logic [1:0]          alusrc_d;
    logic [1:0]          regsel_d;
    logic [ALUOP_W-1:0]  aluop_d;
    logic [NUM_GPIO-1:0] gpio_we_d;
    logic [3:0]          gpio_rsel_d;
    logic                illegal_d;
    logic                unused_ok;

    ctrl_decode #(
        .NUM_GPIO      (NUM_GPIO),
        .GPIO_OUT_BASE (GPIO_OUT_BASE),
        .GPIO_IN_BASE  (GPIO_IN_BASE)
    ) u_decode (
        .instr_valid (instr_valid),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .imm12       (imm12),
        .ctrl        (dec)
    );

    assign unused_ok = ^{dec.gpio_we, dec.is_div};

`ifdef CTRL_MEXT_EN
    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             div_start_d;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        regwrite_d  = 1'b0;
        div_start_d = 1'b0;
        alusrc_d    = alusrc_EX;
        regsel_d    = regsel_EX;
        aluop_d     = aluop_EX;
        gpio_we_d   = gpio_we_EX;
        gpio_rsel_d = gpio_rsel_EX;
        illegal_d   = illegal_EX;
        case (state)
            ST_IDLE: begin
                regwrite_d  = dec.regwrite & ~dec.is_div;
                alusrc_d    = dec.alusrc;
                regsel_d    = dec.regsel;
                aluop_d     = ALUOP_W'(dec.aluop);
                gpio_we_d   = dec.gpio_we[NUM_GPIO-1:0];
                gpio_rsel_d = dec.gpio_rsel;
                illegal_d   = dec.illegal;
                div_start_d = dec.is_div;
                if (dec.is_div) begin
                    state_nxt = ST_DIV_WAIT;
                    cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            ST_DIV_WAIT: begin
                // Decode output is ignored here; the front end is holding the next instruction.
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    regwrite_d = 1'b1;
                    state_nxt  = ST_IDLE;
                    cnt_nxt    = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            div_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div_start <= div_start_d;
        end
    end

    assign stall_FE = (state == ST_DIV_WAIT);
`else
    always_comb begin
        regwrite_d  = dec.regwrite;
        alusrc_d    = dec.alusrc;
        regsel_d    = dec.regsel;
        aluop_d     = ALUOP_W'(dec.aluop);
        gpio_we_d   = dec.gpio_we[NUM_GPIO-1:0];
        gpio_rsel_d = dec.gpio_rsel;
        illegal_d   = dec.illegal;
    end

    assign div_start = 1'b0;
    assign stall_FE  = 1'b0;
`endif

    // Decode -> EX boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_EX  <= 1'b0;
            alusrc_EX    <= '0;
            regsel_EX    <= '0;
            aluop_EX     <= '0;
            gpio_we_EX   <= '0;
            gpio_rsel_EX <= '0;
            illegal_EX   <= 1'b0;
        end else begin
            regwrite_EX  <= regwrite_d;
            alusrc_EX    <= alusrc_d;
            regsel_EX    <= regsel_d;
            aluop_EX     <= aluop_d;
            gpio_we_EX   <= gpio_we_d;
            gpio_rsel_EX <= gpio_rsel_d;
            illegal_EX   <= illegal_d;
        end
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Second-generation control unit for the 3-stage RV32IM core.
- Decodes opcode/funct3/funct7/imm12 in the fetch/decode stage and registers the control bundle into EX (one-cycle latency).
- Generalises GPIO CSR access to NUM_GPIO output and input channels.
- Sequences fixed-latency multi-cycle DIV/REM: issues a start pulse, stalls the front end, then releases a delayed register write.

Parameters:
- NUM_GPIO, 2: number of GPIO output channels and of input channels (1..16).
- GPIO_OUT_BASE, 12'hF00: CSR address of output channel 0; channel k is at GPIO_OUT_BASE+k.
- GPIO_IN_BASE, 12'hF10: CSR address of input channel 0; channel k is at GPIO_IN_BASE+k.
- DIV_CYCLES, 34: cycles from div_start until the quotient/remainder is valid (2..255).
- ALUOP_W, 5: aluop field width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- instr_valid  in  1  decode-stage instruction is valid (0 = bubble)
- op  in  7  opcode
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field
- imm12  in  12  I-type immediate / CSR address
- regwrite_EX  out  1  register-file write enable
- alusrc_EX  out  2  00 rs2, 01 imm12, 10 imm20
- regsel_EX  out  2  01 imm20, 10 ALU, 11 GPIO input
- aluop_EX  out  ALUOP_W  ALU operation
- gpio_we_EX  out  NUM_GPIO  one-hot output-channel write enable
- gpio_rsel_EX  out  4  input channel index
- div_start  out  1  one-cycle divider launch pulse
- stall_FE  out  1  hold PC and decode registers
- illegal_EX  out  1  registered illegal-instruction flag

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM=IDLE; counter=0. Outputs stay 0 on the first edge after deassertion unless a valid instruction is present.
- Every output is a flop updated on posedge clk. Decode-to-EX latency is 1 cycle.
- IDLE, instr_valid=0: next-cycle outputs all 0 (bubble).
- IDLE, valid R-type (0110011): regwrite=1, alusrc=00, regsel=10. Each funct7/funct3 pair maps to a distinct aluop from the package: ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. AND and OR get different codes; signed and unsigned DIV/REM get different codes.
- IDLE, valid I-ALU (0010011): regwrite=1, alusrc=01, regsel=10. Covers ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI; shift type is selected by funct7[5].
- IDLE, valid LUI (0110111): regwrite=1, alusrc=10, regsel=01, aluop=PASS.
- IDLE, valid CSRRW (1110011, funct3=001):
  - imm12 in [GPIO_OUT_BASE, +NUM_GPIO): gpio_we_EX[imm12-GPIO_OUT_BASE]=1, regwrite=0.
  - imm12 in [GPIO_IN_BASE, +NUM_GPIO): regwrite=1, regsel=11, gpio_rsel_EX=imm12-GPIO_IN_BASE.
  - Any other address: illegal.
- Any other valid encoding: illegal_EX=1 and all other outputs 0.
- DIV-class (DIV/DIVU/REM/REMU) in IDLE:
  - Next edge: aluop registered, div_start=1, regwrite_EX=0, FSM→DIV_WAIT, counter loaded with DIV_CYCLES-1.
- DIV_WAIT:
  - stall_FE=1 combinationally from the state. aluop/alusrc/regsel are held; div_start=0; inputs are ignored.
  - The counter decrements each cycle. On the edge where counter==1: regwrite_EX=1 for exactly one cycle, FSM→IDLE, stall_FE drops in that same cycle.
- An instruction presented during DIV_WAIT is not consumed. It is re-decoded in the first IDLE cycle because the front end held it.
- Reset mid-DIV_WAIT: immediate return to IDLE, no regwrite pulse, stall_FE=0.
- Outputs are never X: every case has a default arm.

Optional Feature:
- Macro CTRL_MEXT_EN.
- Defined: funct7=0000001 R-types decode as the M-extension above, including the DIV sequencer.
- Undefined: those encodings raise illegal_EX; FSM, counter, div_start and stall_FE logic are removed; div_start and stall_FE are tied to 0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_LUI, OP_SYS);
  - the aluop_e enum of ALUOP_W bits;
  - alusrc/regsel encodings;
  - the ctrl_bundle_t struct (regwrite, alusrc, regsel, aluop, gpio_we, gpio_rsel, illegal, is_div).
- Sub-module ctrl_decode: purely combinational instruction→ctrl_bundle_t.
- The top module holds the EX registers, DIV FSM and counter.

Test Plan:
- ADD (funct7=0, funct3=000) then SUB (0100000/000) back-to-back → on cycles 1 and 2, regwrite=1, regsel=10, aluop=ADD then SUB; no stall.
- CSRRW imm12=12'hF01 (NUM_GPIO=2) → gpio_we_EX=2'b10, regwrite=0. imm12=12'hF11 → regwrite=1, regsel=11, gpio_rsel_EX=1. imm12=12'hF05 → illegal_EX=1.
- DIVU, DIV_CYCLES=34 → div_start pulses on cycle 1; stall_FE=1 for cycles 1..33; regwrite_EX=1 only on cycle 34; the following ADDI is issued on cycle 35.
- rst asserted asynchronously at cycle 10 of a DIV → outputs 0 within the same cycle, no later regwrite pulse, stall_FE=0.
- instr_valid=0 with op=0110011 → all outputs 0. op=7'b1111111 valid → illegal_EX=1 only.
- Build without CTRL_MEXT_EN, MUL (funct7=0000001) → illegal_EX=1, div_start stays 0.
